// File: rtl/ibex_bus_pkg.sv
// Shared types and helpers for the Ibex host-port arbiter slice.
// Transaction typedefs use the default Ibex 32-bit bus widths.
package ibex_bus_pkg;

    localparam int unsigned BUS_AW = 32;
    localparam int unsigned BUS_DW = 32;

    typedef struct packed {
        logic [BUS_AW-1:0]   addr;
        logic                we;
        logic [BUS_DW/8-1:0] be;
        logic [BUS_DW-1:0]   wdata;
    } ibex_req_t;

    typedef struct packed {
        logic              rvalid;
        logic              err;
        logic [BUS_DW-1:0] rdata;
    } ibex_rsp_t;

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } arb_state_e;

    // Host index width; a single host still needs one bit to form a vector.
    function automatic int unsigned host_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ibex_idx_fifo.sv
// In-order FIFO of host indices, one entry per granted transaction
// still waiting for its response.
module ibex_idx_fifo
    import ibex_bus_pkg::*;
#(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [PW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == (PW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/ibex_host_arb.sv
// Round-robin merge of N Ibex host ports onto one device port, with
// in-order response steering through a routing FIFO.
module ibex_host_arb
    import ibex_bus_pkg::*;
#(
    parameter int unsigned N_HOSTS         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [N_HOSTS-1:0]                 h_req_i,
    input  logic [N_HOSTS*ADDR_WIDTH-1:0]      h_addr_i,
    input  logic [N_HOSTS-1:0]                 h_we_i,
    input  logic [N_HOSTS*DATA_WIDTH/8-1:0]    h_be_i,
    input  logic [N_HOSTS*DATA_WIDTH-1:0]      h_wdata_i,
    output logic [N_HOSTS-1:0]                 h_gnt_o,
    output logic [N_HOSTS-1:0]                 h_rvalid_o,
    output logic [N_HOSTS-1:0]                 h_err_o,
    output logic [N_HOSTS*DATA_WIDTH-1:0]      h_rdata_o,
    output logic                               m_req_o,
    output logic [ADDR_WIDTH-1:0]              m_addr_o,
    output logic                               m_we_o,
    output logic [DATA_WIDTH/8-1:0]            m_be_o,
    output logic [DATA_WIDTH-1:0]              m_wdata_o,
    input  logic                               m_gnt_i,
    input  logic                               m_rvalid_i,
    input  logic                               m_err_i,
    input  logic [DATA_WIDTH-1:0]              m_rdata_i,
    output logic                               orphan_o
);

    localparam int unsigned HOST_IDX_W = host_idx_w(N_HOSTS);
    localparam int unsigned BW         = DATA_WIDTH / 8;

    arb_state_e            r_state;
    logic [HOST_IDX_W-1:0] r_lock_idx;
    logic [HOST_IDX_W-1:0] r_ptr;
    logic                  r_orphan;

    logic [HOST_IDX_W-1:0] w_sel;
    logic                  w_sel_req;
    logic                  w_fire;
    logic [HOST_IDX_W-1:0] w_ptr_nxt;
    logic [HOST_IDX_W-1:0] w_head;
    logic                  w_full;
    logic                  w_empty;

    // While locked the held host is the only candidate; otherwise scan from r_ptr.
    always_comb begin
        int unsigned k;
        k         = 0;
        w_sel     = '0;
        w_sel_req = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_sel     = r_lock_idx;
            w_sel_req = h_req_i[r_lock_idx];
        end else begin
            for (int unsigned i = 0; i < N_HOSTS; i++) begin
                k = (int'(r_ptr) + i) % N_HOSTS;
                if (!w_sel_req && h_req_i[k]) begin
                    w_sel     = HOST_IDX_W'(k);
                    w_sel_req = 1'b1;
                end
            end
        end
    end

    assign m_req_o   = w_sel_req && !w_full;
    assign w_fire    = m_req_o && m_gnt_i;
    assign m_addr_o  = h_addr_i[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_we_o    = h_we_i[w_sel];
    assign m_be_o    = h_be_i[int'(w_sel)*BW +: BW];
    assign m_wdata_o = h_wdata_i[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
    assign w_ptr_nxt = (w_sel == HOST_IDX_W'(N_HOSTS-1)) ? '0 : w_sel + 1'b1;

    always_comb begin
        h_gnt_o = '0;
        if (w_fire) begin
            h_gnt_o[w_sel] = 1'b1;
        end
    end

    always_comb begin
        h_rvalid_o = '0;
        h_err_o    = '0;
        if (m_rvalid_i && !w_empty) begin
            h_rvalid_o[w_head] = 1'b1;
            h_err_o[w_head]    = m_err_i;
        end
    end

    assign h_rdata_o = {N_HOSTS{m_rdata_i}};
    assign orphan_o  = r_orphan;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_OPEN;
            r_lock_idx <= '0;
            r_ptr      <= '0;
            r_orphan   <= 1'b0;
        end else begin
            if (w_fire) begin
                r_ptr <= w_ptr_nxt;
            end
            if (m_req_o && !m_gnt_i) begin
                r_state    <= ST_LOCKED;
                r_lock_idx <= w_sel;
            end else if (w_fire) begin
                r_state <= ST_OPEN;
            end
            if (m_rvalid_i && w_empty) begin
                r_orphan <= 1'b1;
            end
        end
    end

    ibex_idx_fifo #(
        .W     (HOST_IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_route_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_fire),
        .i_din   (w_sel),
        .i_pop   (m_rvalid_i),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: doc/ibex_host_arb.md
Name: ibex_host_arb

Overview:
- Merges N Ibex-protocol host (requester) ports onto one Ibex device port toward system memory.
- Sits directly downstream of the SA-for-Ibex wrapper's host port. Typical setup: host 0 = CPU data port, host 1 = SA DMA host port.
- Grants requesters round-robin and records each grant's source index in an in-order routing FIFO. Returned rvalid/rdata/err are steered back to the requester that issued the transaction.

Parameters:
- N_HOSTS, 2, number of requester ports (2..8).
- MAX_OUTSTANDING, 4, depth of the routing FIFO; the maximum number of granted transactions awaiting rvalid (power of 2, at least 2).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; the byte-enable width is DATA_WIDTH/8.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous, active-low reset.
- h_req_i  in  N_HOSTS  per-host request.
- h_addr_i  in  N_HOSTS*ADDR_WIDTH  per-host address.
- h_we_i  in  N_HOSTS  per-host write enable.
- h_be_i  in  N_HOSTS*DATA_WIDTH/8  per-host byte enables.
- h_wdata_i  in  N_HOSTS*DATA_WIDTH  per-host write data.
- h_gnt_o  out  N_HOSTS  per-host grant.
- h_rvalid_o  out  N_HOSTS  per-host response valid.
- h_err_o  out  N_HOSTS  per-host error; valid with rvalid.
- h_rdata_o  out  N_HOSTS*DATA_WIDTH  per-host read data.
- m_req_o  out  1  merged request to the memory device.
- m_addr_o  out  ADDR_WIDTH  selected address.
- m_we_o  out  1  selected write enable.
- m_be_o  out  DATA_WIDTH/8  selected byte enables.
- m_wdata_o  out  DATA_WIDTH  selected write data.
- m_gnt_i  in  1  device grant.
- m_rvalid_i  in  1  device response valid (responses return in order).
- m_err_i  in  1  device error.
- m_rdata_i  in  DATA_WIDTH  device read data.
- orphan_o  out  1  sticky flag: an rvalid arrived with no transaction outstanding.

Behaviour:
- Reset values:
  - Round-robin pointer = 0, lock clear, FIFO empty, orphan_o = 0.
  - All h_gnt_o, h_rvalid_o, h_err_o = 0.
  - m_req_o = 0.
- Selection:
  - If lock is set, the locked index is selected.
  - Otherwise the selected host is the first asserted h_req_i at or after the pointer, wrapping modulo N_HOSTS.
- Request path (combinational, zero-latency):
  - m_req_o = selected request AND NOT fifo_full.
  - m_addr/we/be/wdata are muxed from the selected host.
  - When no host is requesting, the muxed fields are driven with host 0's fields (don't-care).
- Grant path:
  - h_gnt_o[sel] = m_gnt_i AND m_req_o. Every other grant is 0.
- Lock (Ibex requires req and fields stable until gnt):
  - Set on m_req_o=1 with m_gnt_i=0, holding the selected index.
  - Cleared on the cycle the locked host is granted.
  - While lock is set, no other host is considered.
- Pointer:
  - On a grant to index k, the pointer becomes (k+1) mod N_HOSTS next cycle.
- Routing FIFO:
  - Push the selected index on m_req_o AND m_gnt_i. Pop on m_rvalid_i when not empty.
  - No full-bypass: m_req_o is held low while full, even if m_rvalid_i pops in the same cycle.
  - Simultaneous push and pop when not full: occupancy is unchanged and the pointers advance.
- Response path (combinational):
  - h_rvalid_o[head] = m_rvalid_i AND NOT empty.
  - h_err_o[head] = m_err_i AND m_rvalid_i.
  - All h_rdata_o lanes are driven with m_rdata_i; rvalid qualifies the lane.
- Orphan:
  - m_rvalid_i while the FIFO is empty is dropped and sets orphan_o. orphan_o clears only on reset.
- Device timing: the device returns rvalid at the earliest 1 cycle after gnt. A same-cycle gnt/rvalid pair therefore pops an older entry.
- Reset mid-operation: FIFO, lock and pointer clear immediately. Responses arriving after reset are treated as orphans.
- Occupancy counter width: clog2(MAX_OUTSTANDING)+1.

Decomposition:
- Package ibex_bus_pkg:
  - HOST_IDX_W = clog2(N_HOSTS).
  - Typedef ibex_req_t {addr, we, be, wdata}.
  - Typedef ibex_rsp_t {rvalid, err, rdata}.
- Sub-module ibex_idx_fifo: synchronous FIFO of HOST_IDX_W-bit entries, depth MAX_OUTSTANDING, with full/empty flags and async active-low reset.
- The arbiter, lock and muxes stay in the top module.

Test Plan:
- Single host, no contention:
  - Stimulus: host1 reads 0x100, device grants immediately, rvalid 2 cycles later with rdata 0xDEADBEEF.
  - Required: only h_gnt_o[1] pulses; h_rvalid_o[1] pulses with 0xDEADBEEF; host0 sees nothing.
- Contention:
  - Stimulus: both hosts hold req for 4 grants.
  - Required: grants alternate 0,1,0,1; responses return in the same order to the matching hosts.
- Lock:
  - Stimulus: device holds m_gnt_i=0 for 3 cycles while host0 is selected; host1 raises req at cycle 1.
  - Required: m_addr_o stays host0's address until the grant; host1 is granted next.
- FIFO full:
  - Stimulus: MAX_OUTSTANDING=4, 4 grants issued with no rvalid.
  - Required: m_req_o=0 on the 5th request; it reasserts the cycle after the first rvalid pop.
- Orphan and reset:
  - Stimulus: m_rvalid_i with the FIFO empty, then rstn low mid-burst with 2 transactions outstanding.
  - Required: orphan_o=1 and no h_rvalid_o; after reset all outputs are 0 and the FIFO is empty.
- Error routing:
  - Stimulus: host1 write is granted; device returns rvalid with m_err_i=1.
  - Required: h_err_o[1]=1 together with h_rvalid_o[1]; h_err_o[0]=0.
